// File: rtl/bram_port_master_if.sv
`default_nettype none
// ============================================================================
// Module   : bram_port_master_if
// Purpose  : Request/response streams and BRAM port bus for bram_port_master.
// Revision : 1.0
// ============================================================================
interface bram_port_master_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;

  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic [DATA_W-1:0] bram_dout;

  // Engine side: accepts requests, issues responses, drives the BRAM port.
  modport master (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata,
    input  rsp_ready,
    output bram_we, bram_addr, bram_din,
    input  bram_dout
  );

  // Client/BRAM side: issues requests, consumes responses, models the RAM.
  modport slave (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata,
    output rsp_ready,
    input  bram_we, bram_addr, bram_din,
    output bram_dout
  );

endinterface
`default_nettype wire

// File: rtl/bram_port_master.sv
`default_nettype none
// ============================================================================
// Module   : bram_port_master
// Purpose  : Valid/ready client engine for one BRAM port with a credit-checked
//            in-order response FIFO absorbing the one-cycle read latency.
// Revision : 1.0
// ============================================================================
module bram_port_master #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 32,
  parameter int RSP_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  bram_port_master_if.master  bus,
  output logic                o_busy
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;
  localparam logic [SUM_W-1:0] C_DEPTH = SUM_W'(RSP_DEPTH);

  logic              r_rd_inflight;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [DATA_W-1:0] r_fifo [RSP_DEPTH];

  logic              w_req_ready;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_rsp_valid;
  logic [SUM_W-1:0]  w_used;

  // Credit counts the read already in flight so its data always has a slot.
  assign w_used      = SUM_W'(r_count) + SUM_W'(r_rd_inflight);
  assign w_req_ready = rst_n & (w_used < C_DEPTH);
  assign w_accept    = bus.req_valid & w_req_ready;
  assign w_push      = r_rd_inflight;
  assign w_rsp_valid = (r_count != '0);
  assign w_pop       = w_rsp_valid & bus.rsp_ready;

  assign bus.req_ready = w_req_ready;
  assign bus.bram_we   = w_accept & bus.req_we;
  assign bus.bram_addr = bus.req_addr;
  assign bus.bram_din  = bus.req_wdata;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_rdata = w_rsp_valid ? r_fifo[r_rd_ptr] : '0;
  assign o_busy        = r_rd_inflight | w_rsp_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_inflight <= 1'b0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      r_rd_inflight <= w_accept & ~bus.req_we;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is never cleared; the empty-output mux hides stale entries.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= bus.bram_dout;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bram_port_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_port_master
// Purpose  : Directed self-checking bench with a 512x32 read-first BRAM model.
// Revision : 1.0
// ============================================================================
module tb_bram_port_master;

  localparam int RSP_DEPTH = 4;

  logic clk;
  logic rst_n;
  logic busy;
  logic rdy_dir;
  logic rdy_rand;
  logic rand_mode;

  bram_port_master_if #(.ADDR_W(9), .DATA_W(32)) bus ();

  bram_port_master #(.ADDR_W(9), .DATA_W(32), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .o_busy (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int pops     = 0;
  int stalls   = 0;
  int outstanding = 0;
  logic ovf = 1'b0;
  logic last_we;
  logic [8:0] last_addr;
  logic mon_acc;

  logic [31:0] bram_mem [512];
  logic [31:0] ref_mem  [512];
  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.rsp_ready = rand_mode ? rdy_rand : rdy_dir;

  always @(posedge clk) begin
    #1;
    rdy_rand = 1'($urandom_range(0, 1));
  end

  // Read-first synchronous RAM with one-cycle registered output.
  always @(posedge clk) begin
    if (bus.bram_we) bram_mem[bus.bram_addr] <= bus.bram_din;
    bus.bram_dout <= bram_mem[bus.bram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: reference memory updated on accepted writes, expected data queued on reads.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      outstanding = 0;
    end else begin
      mon_acc = bus.req_valid & bus.req_ready;
      if (mon_acc && bus.req_we) ref_mem[bus.req_addr] = bus.req_wdata;
      if (mon_acc && !bus.req_we) begin
        exp_q.push_back(ref_mem[bus.req_addr]);
        outstanding++;
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        pops++;
        got_q.push_back(bus.rsp_rdata);
        if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
        else check("rsp_data", bus.rsp_rdata, exp_q.pop_front());
        outstanding--;
      end
      if (outstanding > RSP_DEPTH) ovf = 1'b1;
    end
  end

  task automatic do_req(input logic we, input logic [8:0] a, input logic [31:0] d);
    int n = 0;
    logic acc = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    while (!acc && n < 64) begin
      @(negedge clk);
      acc       = bus.req_ready;
      last_we   = bus.bram_we;
      last_addr = bus.bram_addr;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("req_timeout", 32'd0, 32'd1);
    if (n > 1) stalls += n - 1;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc3;
    int base;
    int n;
    logic a;
    logic [31:0] t3_exp [4];

    for (int i = 0; i < 512; i++) begin
      bram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    rst_n = 1'b0;
    rand_mode = 1'b0;
    rdy_dir = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 9'd7;
    bus.req_wdata = 32'h12345678;

    // Reset state, with a write offered to prove bram_we is gated.
    idle(3);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_bram_we",   32'(bus.bram_we),   32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_rdata",     bus.rsp_rdata,      32'd0);
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rel_req_ready", 32'(bus.req_ready), 32'd1);
    idle(1);

    // Single write then read with exact latency.
    rdy_dir = 1'b1;
    do_req(1'b1, 9'd5, 32'hDEADBEEF);
    check("t1_we_wr", 32'(last_we), 32'd1);
    do_req(1'b0, 9'd5, 32'd0);
    bus.req_valid = 1'b0;
    check("t1_we_rd",   32'(last_we),       32'd0);
    check("t1_addr_rd", 32'(last_addr),     32'd5);
    check("t1_vld_T1",  32'(bus.rsp_valid), 32'd0);
    idle(1);
    check("t1_vld_T2",  32'(bus.rsp_valid), 32'd1);
    check("t1_data",    bus.rsp_rdata,      32'hDEADBEEF);
    check("t1_we_idle", 32'(bus.bram_we),   32'd0);
    idle(1);
    check("t1_vld_done", 32'(bus.rsp_valid), 32'd0);
    check("t1_busy",     32'(busy),          32'd0);

    // Full fill then 512 back-to-back reads.
    stalls = 0;
    for (int i = 0; i < 512; i++) do_req(1'b1, 9'(i), 32'(i * 3));
    base = pops;
    for (int i = 0; i < 512; i++) do_req(1'b0, 9'(i), 32'd0);
    bus.req_valid = 1'b0;
    idle(2);
    check("t2_stalls", 32'(stalls),       32'd0);
    check("t2_pops",   32'(pops - base),  32'd512);
    check("t2_empty",  32'(bus.rsp_valid), 32'd0);

    // Back-pressure: credit limits acceptance to RSP_DEPTH reads.
    rdy_dir = 1'b0;
    acc3 = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 9'd0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      a = bus.req_ready;
      @(posedge clk);
      #1;
      if (a) begin
        acc3++;
        bus.req_addr = bus.req_addr + 9'd1;
      end
    end
    bus.req_valid = 1'b0;
    check("t3_accepted", 32'(acc3),         32'd4);
    check("t3_rdy_low",  32'(bus.req_ready), 32'd0);
    check("t3_busy",     32'(busy),          32'd1);
    got_q.delete();
    rdy_dir = 1'b1;
    idle(6);
    t3_exp = '{32'd0, 32'd3, 32'd6, 32'd9};
    check("t3_drained", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < got_q.size()) check("t3_order", got_q[i], t3_exp[i]);
    check("t3_rdy_back", 32'(bus.req_ready), 32'd1);
    stalls = 0;
    do_req(1'b0, 9'd10, 32'd0);
    bus.req_valid = 1'b0;
    check("t3_resume", 32'(stalls), 32'd0);
    idle(3);

    // Random 70/30 read/write stream against the reference memory.
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++)
      do_req($urandom_range(0, 9) < 3, 9'($urandom_range(0, 511)), $urandom);
    bus.req_valid = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      idle(1);
      n++;
    end
    rand_mode = 1'b0;
    check("t4_busy",  32'(busy),          32'd0);
    check("t4_queue", 32'(exp_q.size()),  32'd0);
    check("t4_ovf",   32'(ovf),           32'd0);

    // Write/read at top address, then address 0.
    got_q.delete();
    do_req(1'b1, 9'h000, 32'hA5A5A5A5);
    do_req(1'b1, 9'h1FF, 32'h11111111);
    do_req(1'b0, 9'h1FF, 32'd0);
    do_req(1'b0, 9'h000, 32'd0);
    bus.req_valid = 1'b0;
    idle(4);
    check("t5_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      check("t5_top",  got_q[0], 32'h11111111);
      check("t5_zero", got_q[1], 32'hA5A5A5A5);
    end

    // Reset with one read in flight and two buffered.
    rdy_dir = 1'b0;
    do_req(1'b0, 9'd20, 32'd0);
    do_req(1'b0, 9'd21, 32'd0);
    do_req(1'b0, 9'd22, 32'd0);
    bus.req_valid = 1'b0;
    check("t6_pre_busy",  32'(busy),          32'd1);
    check("t6_pre_valid", 32'(bus.rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("t6_rst_busy",  32'(busy),          32'd0);
    check("t6_rst_rdata", bus.rsp_rdata,      32'd0);
    idle(2);
    base = pops;
    rst_n = 1'b1;
    rdy_dir = 1'b1;
    idle(4);
    check("t6_no_stale", 32'(pops - base),   32'd0);
    check("t6_valid",    32'(bus.rsp_valid), 32'd0);
    got_q.delete();
    do_req(1'b0, 9'h1FF, 32'd0);
    bus.req_valid = 1'b0;
    idle(3);
    check("t6_new_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1) check("t6_new_data", got_q[0], 32'h11111111);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
